// File: rtl/start_token_srl_fifo_pkg.sv
// Shared constants and helpers for the start-token SRL FIFO.
// The occupancy counter is one bit wider than the SRL address so it can hold DEPTH (or DEPTH+1).
package start_token_srl_fifo_pkg;

    function automatic int occ_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/start_token_srl_fifo_shiftreg.sv
// Plain SRL storage: every write shifts all entries up by one and writes din into entry 0.
// No reset on the storage; the read port is a combinational mux on addr.
module start_token_srl_fifo_shiftreg #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_mem[i] <= r_mem[i-1];
            end
            r_mem[0] <= din;
        end
    end

    assign dout = r_mem[addr];

endmodule

// File: rtl/start_token_srl_fifo.sv
// Start-token / stream FIFO: pointer, occupancy and flag control around an SRL,
// with an optional registered output stage that adds one entry of capacity.
module start_token_srl_fifo
    import start_token_srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8,
    parameter int OUT_REG    = 0
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    if_write,
    input  logic                    if_write_ce,
    input  logic [DATA_WIDTH-1:0]   if_din,
    output logic                    if_full_n,
    input  logic                    if_read,
    input  logic                    if_read_ce,
    output logic [DATA_WIDTH-1:0]   if_dout,
    output logic                    if_empty_n,
    output logic [ADDR_WIDTH:0]     if_num_data
);

    localparam int                    CNT_W    = occ_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    if (DEPTH > (1 << ADDR_WIDTH) || DEPTH < 2) begin : g_bad_depth
        $error("start_token_srl_fifo: DEPTH must be in [2, 2**ADDR_WIDTH]");
    end

    logic                  w_push;
    logic                  w_pop;
    logic                  w_srl_push;
    logic                  w_srl_pop;
    logic [DATA_WIDTH-1:0] w_srl_dout;
    logic [CNT_W-1:0]      r_srl_cnt;
    logic [CNT_W-1:0]      w_srl_cnt_nxt;
    logic [CNT_W-1:0]      r_num_data;
    logic [CNT_W-1:0]      w_num_data_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  w_empty_n_nxt;
    logic [DATA_WIDTH-1:0] r_oreg;

    // Handshake: a transfer happens on an edge only when request, clock-enable and the
    // registered flag (full_n for writes, empty_n for reads) are all high before that edge.
    always_comb begin
        w_push     = if_write & if_write_ce & r_full_n;
        w_pop      = if_read & if_read_ce & r_empty_n;
        w_srl_push = w_push;
        if (OUT_REG != 0) begin
            w_srl_pop = (r_srl_cnt != '0) && (!r_empty_n || w_pop);
        end else begin
            w_srl_pop = w_pop;
        end
    end

    // The oldest SRL entry sits at r_addr; pushes shift it up, so the pointer follows.
    always_comb begin
        w_srl_cnt_nxt = r_srl_cnt;
        w_addr_nxt    = r_addr;
        case ({w_srl_push, w_srl_pop})
            2'b10: begin
                w_srl_cnt_nxt = r_srl_cnt + CNT_ONE;
                w_addr_nxt    = (r_srl_cnt == '0) ? '0 : r_addr + ADDR_ONE;
            end
            2'b01: begin
                w_srl_cnt_nxt = r_srl_cnt - CNT_ONE;
                w_addr_nxt    = (r_srl_cnt == CNT_ONE) ? '0 : r_addr - ADDR_ONE;
            end
            default: begin
                w_srl_cnt_nxt = r_srl_cnt;
                w_addr_nxt    = r_addr;
            end
        endcase
    end

    always_comb begin
        w_num_data_nxt = r_num_data;
        case ({w_push, w_pop})
            2'b10:   w_num_data_nxt = r_num_data + CNT_ONE;
            2'b01:   w_num_data_nxt = r_num_data - CNT_ONE;
            default: w_num_data_nxt = r_num_data;
        endcase
    end

    // With the output stage, empty_n is the output-register valid bit.
    always_comb begin
        w_empty_n_nxt = r_empty_n;
        if (OUT_REG != 0) begin
            if (w_srl_pop) begin
                w_empty_n_nxt = 1'b1;
            end else if (w_pop) begin
                w_empty_n_nxt = 1'b0;
            end
        end else begin
            w_empty_n_nxt = (w_srl_cnt_nxt != '0);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_srl_cnt  <= '0;
            r_num_data <= '0;
            r_addr     <= '0;
            r_full_n   <= 1'b1;
            r_empty_n  <= 1'b0;
            r_oreg     <= '0;
        end else begin
            r_srl_cnt  <= w_srl_cnt_nxt;
            r_num_data <= w_num_data_nxt;
            r_addr     <= w_addr_nxt;
            r_full_n   <= (w_srl_cnt_nxt < DEPTH_C);
            r_empty_n  <= w_empty_n_nxt;
            if (OUT_REG != 0 && w_srl_pop) begin
                r_oreg <= w_srl_dout;
            end
        end
    end

    start_token_srl_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (ap_clk),
        .we   (w_srl_push),
        .addr (r_addr),
        .din  (if_din),
        .dout (w_srl_dout)
    );

    assign if_full_n   = r_full_n;
    assign if_empty_n  = r_empty_n;
    assign if_num_data = r_num_data;
    assign if_dout     = (OUT_REG != 0) ? r_oreg : w_srl_dout;

endmodule

// File: tb/tb_start_token_srl_fifo.sv
// Bench for start_token_srl_fifo: one instance without and one with the output register,
// directed vector table, hand-written corner sequences and a queue scoreboard.
module tb_start_token_srl_fifo;

    logic       clk;
    logic       rst_n   [2];
    logic       wr      [2];
    logic       wce     [2];
    logic [3:0] din     [2];
    logic       rd      [2];
    logic       rce     [2];
    logic       full_n  [2];
    logic       empty_n [2];
    logic [3:0] dout    [2];
    logic [3:0] num     [2];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_n;
        logic       wr;
        logic       rd;
        logic [3:0] din;
        logic       exp_full_n;
        logic       exp_empty_n;
        logic [3:0] exp_num;
        logic       chk_dout;
        logic [3:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    start_token_srl_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .DEPTH(8), .OUT_REG(0)) dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n[0]),
        .if_write(wr[0]), .if_write_ce(wce[0]), .if_din(din[0]), .if_full_n(full_n[0]),
        .if_read(rd[0]), .if_read_ce(rce[0]), .if_dout(dout[0]), .if_empty_n(empty_n[0]),
        .if_num_data(num[0])
    );

    start_token_srl_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .DEPTH(8), .OUT_REG(1)) dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n[1]),
        .if_write(wr[1]), .if_write_ce(wce[1]), .if_din(din[1]), .if_full_n(full_n[1]),
        .if_read(rd[1]), .if_read_ce(rce[1]), .if_dout(dout[1]), .if_empty_n(empty_n[1]),
        .if_num_data(num[1])
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic w, input logic [3:0] di, input logic r);
        wr[d]  = w;
        wce[d] = 1'b1;
        din[d] = di;
        rd[d]  = r;
        rce[d] = 1'b1;
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 4'd0, 1'b0);
        drive(1, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic reset_all();
        idle_all();
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rn, input logic w, input logic r, input logic [3:0] di,
                                input logic ef, input logic ee, input logic [3:0] en,
                                input logic cd, input logic [3:0] ed);
        vec_t v;
        v.rst_n = rn; v.wr = w; v.rd = r; v.din = di;
        v.exp_full_n = ef; v.exp_empty_n = ee; v.exp_num = en;
        v.chk_dout = cd; v.exp_dout = ed;
        return v;
    endfunction

    // Empty FIFO, one push of v: visible after 1 edge without, 2 edges with output register.
    task automatic latency(input logic [3:0] v);
        reset_all();
        drive(0, 1'b1, v, 1'b0);
        drive(1, 1'b1, v, 1'b0);
        step();
        idle_all();
        chk("lat0_empty_n", empty_n[0], 1);
        chk("lat0_dout", dout[0], v);
        chk("lat1_early_empty_n", empty_n[1], 0);
        chk("lat1_num", num[1], 1);
        step();
        chk("lat1_empty_n", empty_n[1], 1);
        chk("lat1_dout", dout[1], v);
    endtask

    // Scoreboard: expected queue fed by accepted pushes, drained by accepted pops.
    task automatic run_random(input int d, input int n);
        logic [3:0] exp_q[$];
        logic       w, wc, r, rc, push_ok, pop_ok;
        logic [3:0] di;
        int         pw;
        reset_all();
        for (int c = 0; c < n; c++) begin
            pw = ((c / 400) % 2 == 0) ? 70 : 30;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < (100 - pw));
            wc = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 3) != 0);
            di = 4'($urandom_range(0, 15));
            wr[d] = w; wce[d] = wc; din[d] = di; rd[d] = r; rce[d] = rc;
            push_ok = w & wc & full_n[d];
            pop_ok  = r & rc & empty_n[d];
            if (pop_ok) begin
                if (exp_q.size() == 0) begin
                    chk("rand_underflow", empty_n[d], 0);
                end else begin
                    chk("rand_dout", dout[d], exp_q.pop_front());
                end
            end
            if (push_ok) exp_q.push_back(di);
            step();
            chk("rand_num", num[d], exp_q.size());
            if (d == 0) begin
                chk("rand0_full_n", full_n[d], exp_q.size() < 8);
                chk("rand0_empty_n", empty_n[d], exp_q.size() > 0);
            end else begin
                if (exp_q.size() == 0) chk("rand1_empty_n", empty_n[d], 0);
                if (exp_q.size() == 9) chk("rand1_full_n", full_n[d], 0);
            end
        end
        wr[d] = 1'b0; rd[d] = 1'b0;
    endtask

    initial begin
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        idle_all();

        // Vector table for OUT_REG=0: reset, fill 0..7, rejected 9th push, drain in order.
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'(i - 1), (i < 8), 1'b1, 4'(i), 1'b1, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 4'd8, 1'b1, 4'd0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, (k < 8), 4'(8 - k), (k < 8), 4'(k)));

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n[0] = vecs[i].rst_n;
            drive(0, vecs[i].wr, vecs[i].din, vecs[i].rd);
            step();
            chk($sformatf("vec%0d_full_n", i), full_n[0], vecs[i].exp_full_n);
            chk($sformatf("vec%0d_empty_n", i), empty_n[0], vecs[i].exp_empty_n);
            chk($sformatf("vec%0d_num", i), num[0], vecs[i].exp_num);
            if (vecs[i].chk_dout) chk($sformatf("vec%0d_dout", i), dout[0], vecs[i].exp_dout);
        end
        rst_n[0] = 1'b1;
        idle_all();

        latency(4'd5);

        // Full FIFO with push+pop: only the pop is taken; then a push+pop keeps count 7.
        reset_all();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 4'(8 + i), 1'b0);
            step();
        end
        chk("full_full_n", full_n[0], 0);
        drive(0, 1'b1, 4'd3, 1'b1);
        step();
        chk("full_pp_num", num[0], 7);
        chk("full_pp_full_n", full_n[0], 1);
        chk("full_pp_dout", dout[0], 9);
        drive(0, 1'b1, 4'd4, 1'b1);
        step();
        chk("full_pp2_num", num[0], 7);
        chk("full_pp2_dout", dout[0], 10);
        for (int i = 0; i < 7; i++) begin
            chk("full_drain_dout", dout[0], (i < 6) ? 10 + i : 4);
            drive(0, 1'b0, 4'd0, 1'b1);
            step();
        end
        idle_all();
        chk("full_drain_empty_n", empty_n[0], 0);
        chk("full_drain_num", num[0], 0);

        // OUT_REG=1: nine pushes fit, the tenth is refused, nine pops come back in order.
        reset_all();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1'b1, 4'(i + 1), 1'b0);
            step();
            chk("oreg_fill_num", num[1], (i < 9) ? i + 1 : 9);
            chk("oreg_fill_full_n", full_n[1], i < 8);
        end
        idle_all();
        for (int i = 0; i < 9; i++) begin
            chk("oreg_drain_empty_n", empty_n[1], 1);
            chk("oreg_drain_dout", dout[1], i + 1);
            drive(1, 1'b0, 4'd0, 1'b1);
            step();
        end
        idle_all();
        chk("oreg_drain_final_empty_n", empty_n[1], 0);
        chk("oreg_drain_final_num", num[1], 0);

        // Reset while half full, with push+pop on the same edge.
        reset_all();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 4'(i + 6), 1'b0);
            drive(1, 1'b1, 4'(i + 6), 1'b0);
            step();
        end
        idle_all();
        step();
        chk("half_num0", num[0], 4);
        chk("half_num1", num[1], 4);
        drive(0, 1'b1, 4'd1, 1'b1);
        drive(1, 1'b1, 4'd1, 1'b1);
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        idle_all();
        for (int d = 0; d < 2; d++) begin
            chk("rst_empty_n", empty_n[d], 0);
            chk("rst_full_n", full_n[d], 1);
            chk("rst_num", num[d], 0);
        end
        drive(0, 1'b1, 4'd3, 1'b0);
        drive(1, 1'b1, 4'd3, 1'b0);
        step();
        idle_all();
        chk("rst_push0_empty_n", empty_n[0], 1);
        chk("rst_push0_dout", dout[0], 3);
        chk("rst_push1_early_empty_n", empty_n[1], 0);
        step();
        chk("rst_push1_empty_n", empty_n[1], 1);
        chk("rst_push1_dout", dout[1], 3);

        // Clock-enables low mask the request completely.
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, 1'b1, 4'd7, 1'b0);
                wce[d] = 1'b0;
            end
            step();
            chk("wce_num0", num[0], 1);
            chk("wce_num1", num[1], 1);
        end
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, 1'b0, 4'd0, 1'b1);
                rce[d] = 1'b0;
            end
            step();
            chk("rce_num0", num[0], 1);
            chk("rce_empty_n1", empty_n[1], 1);
            chk("rce_dout1", dout[1], 3);
        end
        idle_all();

        run_random(0, 10000);
        run_random(1, 10000);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
